// File: rtl/risc_ctrl_pkg.sv
// Shared opcode and state encodings for the sequenced RISC controller.
// Pure definitions: no logic, no latency, no flow control.
package risc_ctrl_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    ST_INST_ADDR  = 4'd0,
    ST_INST_FETCH = 4'd1,
    ST_INST_LOAD  = 4'd2,
    ST_IDLE       = 4'd3,
    ST_OP_ADDR    = 4'd4,
    ST_OP_FETCH   = 4'd5,
    ST_ALU_OP     = 4'd6,
    ST_STORE      = 4'd7,
    ST_HALTED     = 4'd8
  } state_t;

  function automatic logic is_alu_load(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_seq_controller_mem_wait_timer.sv
// Memory-phase wait counter: done after MEM_LAT extra cycles, optionally gated by mem_ready.
// Latency MEM_LAT+1 cycles from start; mem_ready low holds done low indefinitely.
module mem_wait_timer #(
  parameter int MEM_LAT   = 0,
  parameter int USE_READY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mem_ready,
  output logic done
);

  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CW-1:0] LAT = CW'(MEM_LAT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LAT so a long ready stall cannot wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (cnt_q != LAT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == LAT) && ((USE_READY == 0) || mem_ready);

endmodule

// File: rtl/risc_seq_controller.sv
// Eight-phase RISC sequencer with memory wait states, sticky HALTED and illegal-opcode flag.
// Moore strobes per phase; memory phases stall until the wait timer reports done.
module risc_seq_controller
  import risc_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 3,
  parameter int MEM_LAT   = 0,
  parameter int USE_READY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                halt,
  output logic                inc_pc,
  output logic                ld_ac,
  output logic                ld_pc,
  output logic                wr,
  output logic                data_e,
  output logic                halted,
  output logic                illegal_op,
  output logic [3:0]          state_o
);

  state_t     state_q, state_d;
  logic       illegal;
  logic [2:0] op;
  logic       is_hlt, is_skz, is_sto, is_jmp, is_ld;
  logic       done;
  logic       start;

  // Opcodes beyond the architectural range decode to nothing, i.e. a NOP.
  assign illegal = 32'(opcode) >= 32'd8;
  assign op      = opcode[2:0];
  assign is_hlt  = !illegal && (op == OP_HLT);
  assign is_skz  = !illegal && (op == OP_SKZ);
  assign is_sto  = !illegal && (op == OP_STO);
  assign is_jmp  = !illegal && (op == OP_JMP);
  assign is_ld   = !illegal && is_alu_load(op);

  // Any state change restarts the count, so every memory phase begins at zero.
  assign start = (state_d != state_q);

  mem_wait_timer #(
    .MEM_LAT  (MEM_LAT),
    .USE_READY(USE_READY)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_ready(mem_ready),
    .done     (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INST_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INST_ADDR:  state_d = ST_INST_FETCH;
      ST_INST_FETCH: if (done) state_d = ST_INST_LOAD;
      ST_INST_LOAD:  state_d = ST_IDLE;
      ST_IDLE:       state_d = is_hlt ? ST_HALTED : ST_OP_ADDR;
      ST_HALTED:     if (resume) state_d = ST_OP_ADDR;
      ST_OP_ADDR:    state_d = ST_OP_FETCH;
      ST_OP_FETCH:   if (is_sto || done) state_d = ST_ALU_OP;
      ST_ALU_OP:     state_d = ST_STORE;
      ST_STORE:      if (!is_sto || done) state_d = ST_INST_ADDR;
      default:       state_d = ST_INST_ADDR;
    endcase
  end

  always_comb begin
    sel        = 1'b0;
    rd         = 1'b0;
    ld_ir      = 1'b0;
    halt       = 1'b0;
    inc_pc     = 1'b0;
    ld_ac      = 1'b0;
    ld_pc      = 1'b0;
    wr         = 1'b0;
    data_e     = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      ST_INST_ADDR:  sel = 1'b1;
      ST_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      ST_INST_LOAD: begin
        sel   = 1'b1;
        ld_ir = 1'b1;
      end
      ST_IDLE: begin
        halt       = is_hlt;
        inc_pc     = is_skz && zero;
        illegal_op = illegal;
      end
      ST_OP_FETCH:   rd = !is_sto;
      ST_ALU_OP: begin
        ld_ac = is_ld;
        ld_pc = is_jmp;
      end
      ST_STORE: begin
        wr     = is_sto;
        data_e = is_sto;
      end
      ST_HALTED:     halted = 1'b1;
      default:       ;
    endcase
  end

  assign state_o = state_q;

endmodule
